obi_sram_bridge: RTL
====================

// Module: obi_sram_bridge
// PURPOSE
// - OBI slave that sits directly downstream of the Wishbone-to-OBI bridge.
// - Converts OBI A/R-channel transactions into accesses on a single-port synchronous SRAM macro.
// - Decodes a fixed address window and inserts optional grant wait-states.
// - Returns rvalid/rdata after the macro's fixed read latency.
// PARAMETERS
// - ADDR_WIDTH  8             SRAM word-address bits (depth = 2**ADDR_WIDTH 32-bit words)
// - BASE_ADDR   32'h3000_0000 byte base of window; window size 4*2**ADDR_WIDTH, aligned
// - RD_LATENCY  1             clocks from SRAM sample edge to valid sram_dout_i; legal 1..4
// - GNT_WAIT    0             req cycles held before gnt; 0 = same-cycle grant; legal 0..7
// - WR_RVALID   0             1 = emit rvalid for writes (full OBI); 0 = reads only
// PORTS
// - clk_i          in   1           clock, all state on rising edge
// - rst_i          in   1           async reset, active high
// - req_i          in   1           OBI request
// - gnt_o          out  1           OBI grant
// - addr_i         in   32          OBI byte address
// - we_i           in   1           1 = write
// - be_i           in   4           byte enables
// - wdata_i        in   32          write data
// - rvalid_o       out  1           response valid, 1-cycle pulse
// - rdata_o        out  32          read data, qualified by rvalid_o
// - err_o          out  1           out-of-window flag; present only with OBI_SRAM_ERR_EN
// - sram_csb_o     out  1           chip select, active low
// - sram_web_o     out  1           write enable, active low
// - sram_wmask_o   out  4           byte write mask, = be_i
// - sram_addr_o    out  ADDR_WIDTH  word address, = addr_i[ADDR_WIDTH+1:2]
// - sram_din_o     out  32          = wdata_i
// - sram_dout_i    in   32          SRAM read data
// BEHAVIOUR
// - Reset (async, held while rst_i=1):
//   - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, sram_csb_o=1, sram_web_o=1.
//   - Wait counter and response pipe are cleared.
// - Grant:
//   - 3-bit counter wcnt; gnt_o = req_i && (wcnt==GNT_WAIT).
//   - req_i && !gnt_o: wcnt++. Accept (req_i&&gnt_o) or req_i=0: wcnt<=0.
//   - Dropping req_i before grant aborts the transaction: no SRAM access, no response.
//   - GNT_WAIT=0: grant is combinational, one accept per cycle possible (back-to-back).
// - Decode:
//   - hit = addr_i in [BASE_ADDR, BASE_ADDR+4*2**ADDR_WIDTH).
//   - addr_i[1:0] ignored.
// - SRAM drive (combinational):
//   - sram_csb_o = !(accept && hit && (!we_i || |be_i)).
//   - sram_web_o = !(accept && we_i).
//   - Miss or be_i==0 write: granted, no SRAM access, write dropped.
// - Response pipe: RD_LATENCY-deep shift register of {valid, miss}.
//   - valid = accept && (!we_i || WR_RVALID).
//   - Accept in cycle t -> rvalid_o=1 in cycle t+RD_LATENCY for exactly one cycle.
//   - Back-to-back accepts -> back-to-back rvalid, in order.
//   - rdata_o = (rvalid_o && !miss) ? sram_dout_i : 32'h0. No registering; relies on SRAM output timing.
//   - Writes with WR_RVALID=1: rdata_o=0.
// - Upstream wb_to_obi acks writes itself one cycle after grant. It must be paired with WR_RVALID=0;
//   otherwise a write rvalid can falsely ack a following read.
// - Reset mid-operation clears the pipe: in-flight responses are discarded and never emitted.
// - No rready: responses cannot be stalled.
// CONFIGURATION
// - OBI_SRAM_ERR_EN defined:
//   - err_o port exists. err_o = rvalid_o && miss.
//   - Miss reads return 32'h0 with err_o=1.
// - OBI_SRAM_ERR_EN undefined:
//   - No err_o port. Misses silently return 32'h0 and drop writes.
// TESTING
// - Reset: rst_i=1 mid-read (RD_LATENCY=2) -> no rvalid_o after release; csb=1, gnt_o=0 during reset.
// - Write/read, GNT_WAIT=0:
//   - Write 0x3000_0010 = 0xCAFE_F00D, be=4'hF -> sram_addr_o=4, web=0 same cycle, no rvalid_o.
//   - Read 0x3000_0010 -> rvalid_o at t+1, rdata_o=0xCAFE_F00D.
// - Byte enables: write 0xAABBCCDD be=4'b0101 over 0x11223344 -> read returns 0x11BB33DD.
//   - be=0 write -> csb stays 1.
// - Wait-states, GNT_WAIT=3: req held -> gnt_o in 4th cycle.
//   - req dropped after 2 cycles -> no gnt, no SRAM access, wcnt back to 0.
// - Pipelining, RD_LATENCY=3: 4 back-to-back reads of words 0..3 -> 4 consecutive rvalid_o pulses
//   starting t+3, data in order.
// - Miss: read 0x4000_0000 -> rvalid_o with rdata_o=0, csb=1.
//   - With OBI_SRAM_ERR_EN: err_o=1. WR_RVALID=1: write -> rvalid_o at t+RD_LATENCY.

Source files
------------

// File: rtl/obi_sram_bridge.sv
// OBI slave to single-port synchronous SRAM bridge with address window decode.
// Define OBI_SRAM_ERR_EN to add the err_o out-of-window response flag.
module obi_sram_bridge #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned GNT_WAIT   = 0,
    parameter bit          WR_RVALID  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
`ifdef OBI_SRAM_ERR_EN
    output logic                  err_o,
`endif
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [3:0]            sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_din_o,
    input  logic [31:0]           sram_dout_i
);

    localparam int unsigned PW = 3 * RD_LATENCY;
    localparam logic [2:0]  GW = 3'(GNT_WAIT);

    logic [2:0]    wcnt;
    logic [2:0]    wcnt_d;
    logic          accept;
    logic          hit;
    logic          rsp_v;
    logic [2:0]    stage_in;
    logic [2:0]    stage_out;
    logic [PW-1:0] pipe_q;
    logic          out_miss;
    logic          out_zero;
    logic          unused_addr;

    assign unused_addr = ^addr_i[1:0];

    // Window is aligned to its size, so only the upper bits need matching.
    assign hit = (addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    always_comb begin
        gnt_o  = req_i && !rst_i && (wcnt == GW);
        wcnt_d = 3'd0;
        if (req_i && !gnt_o) begin
            wcnt_d = wcnt + 3'd1;
        end
    end

    assign accept = req_i && gnt_o;

    assign sram_csb_o   = !(accept && hit && (!we_i || (|be_i)));
    assign sram_web_o   = !(accept && we_i);
    assign sram_wmask_o = be_i;
    assign sram_addr_o  = addr_i[ADDR_WIDTH+1:2];
    assign sram_din_o   = wdata_i;

    // Stage bits: {valid, miss, force-zero data}.
    assign rsp_v    = accept && (!we_i || WR_RVALID);
    assign stage_in = {rsp_v, !hit, !hit || we_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt   <= 3'd0;
            pipe_q <= '0;
        end else begin
            wcnt   <= wcnt_d;
            pipe_q <= PW'({pipe_q, stage_in});
        end
    end

    assign stage_out = pipe_q[PW-1 -: 3];
    assign rvalid_o  = stage_out[2];
    assign out_miss  = stage_out[1];
    assign out_zero  = stage_out[0];

    assign rdata_o = (rvalid_o && !out_zero) ? sram_dout_i : 32'h0;

`ifdef OBI_SRAM_ERR_EN
    assign err_o = rvalid_o && out_miss;
`else
    logic unused_miss;
    assign unused_miss = out_miss;
`endif

endmodule
